motoro3_gate_driver: RTL and testbench

Downstream stage of the PWM generator: converts the single-rail `pwm` pulse train and the commutation step `sgStep` into the six MOSFET gate drives of the three-phase bridge. Decodes each step pair into a bridge sector, gates the active high-side leg with `pwm`, and holds the sink low-side leg on. Inserts a programmable all-off dead time on every sector change, so both switches of a leg are never on together. Also counts commutations and flags illegal sector jumps.

---
 rtl/motoro3_gate_driver.sv | 156 +++++++++++++++
 tb/tb_motoro3_gate_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_gate_driver.sv
// Three-phase bridge gate driver: decodes the commutation step into a sector,
// gates the high-side leg with pwm and inserts an all-off dead time on every sector change.
module motoro3_gate_driver #(
  parameter int DT_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwmActive1,
  input  logic             pwm,
  input  logic [3:0]       sgStep,
  input  logic [DT_W-1:0]  m3r_deadTime,
  output logic [5:0]       gate,
  output logic [2:0]       sector,
  output logic             deadBusy,
  output logic [CNT_W-1:0] commCnt,
  output logic             stepFault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             act_q, act_d;
  logic             pwm_q, pwm_d;
  logic [3:0]       step_q, step_d;
  logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       sector_q, sector_d;
  logic [5:0]       gate_q, gate_d;
  logic             dead_busy_q, dead_busy_d;
  logic [CNT_W-1:0] comm_cnt_q, comm_cnt_d;
  logic             step_fault_q, step_fault_d;

  logic             step_valid;
  logic [2:0]       cur_tgt;
  logic [DT_W-1:0]  dt_load;
  logic [2:0]       sec_next, sec_prev;

  // Bit order {CL,CH,BL,BH,AL,AH}; high leg carries pwm, low leg is held on.
  function automatic logic [5:0] gate_pattern(input logic [2:0] s, input logic p);
    logic [5:0] g;
    g = 6'b000000;
    case (s)
      3'd0: begin g[0] = p; g[3] = 1'b1; end
      3'd1: begin g[0] = p; g[5] = 1'b1; end
      3'd2: begin g[2] = p; g[5] = 1'b1; end
      3'd3: begin g[2] = p; g[1] = 1'b1; end
      3'd4: begin g[4] = p; g[1] = 1'b1; end
      3'd5: begin g[4] = p; g[3] = 1'b1; end
      default: g = 6'b000000;
    endcase
    return g;
  endfunction

  always_comb begin
    step_valid = (step_q < 4'd12);
    cur_tgt    = step_q[3:1];
    dt_load    = (m3r_deadTime == '0) ? DT_W'(1) : m3r_deadTime;
    sec_next   = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    sec_prev   = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
  end

  always_comb begin
    act_d        = pwmActive1;
    pwm_d        = pwm;
    step_d       = sgStep;
    state_d      = state_q;
    dt_cnt_d     = dt_cnt_q;
    tgt_d        = tgt_q;
    sector_d     = sector_q;
    comm_cnt_d   = comm_cnt_q;
    step_fault_d = step_fault_q;

    // Abort wins over everything; all gates off means no dead time is needed.
    if (!act_q || !step_valid) begin
      state_d  = IDLE;
      sector_d = 3'd7;
      dt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = DEAD;
          dt_cnt_d = dt_load;
          tgt_d    = cur_tgt;
        end
        DEAD: begin
          tgt_d = cur_tgt;
          if (dt_cnt_q <= DT_W'(1)) begin
            state_d    = RUN;
            sector_d   = tgt_q;
            comm_cnt_d = comm_cnt_q + CNT_W'(1);
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        RUN: begin
          if (cur_tgt != sector_q) begin
            state_d  = DEAD;
            dt_cnt_d = dt_load;
            tgt_d    = cur_tgt;
            if ((cur_tgt != sec_next) && (cur_tgt != sec_prev)) begin
              step_fault_d = 1'b1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          sector_d = 3'd7;
        end
      endcase
    end

    gate_d      = (state_d == RUN) ? gate_pattern(sector_d, pwm_q) : 6'b000000;
    dead_busy_d = (state_d == DEAD);
  end

  // Falling-edge update keeps this stage aligned with the PWM generator.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      act_q        <= 1'b0;
      pwm_q        <= 1'b0;
      step_q       <= 4'd0;
      dt_cnt_q     <= '0;
      tgt_q        <= 3'd0;
      sector_q     <= 3'd7;
      gate_q       <= 6'b000000;
      dead_busy_q  <= 1'b0;
      comm_cnt_q   <= '0;
      step_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pwm_q        <= pwm_d;
      step_q       <= step_d;
      dt_cnt_q     <= dt_cnt_d;
      tgt_q        <= tgt_d;
      sector_q     <= sector_d;
      gate_q       <= gate_d;
      dead_busy_q  <= dead_busy_d;
      comm_cnt_q   <= comm_cnt_d;
      step_fault_q <= step_fault_d;
    end
  end

  assign gate      = gate_q;
  assign sector    = sector_q;
  assign deadBusy  = dead_busy_q;
  assign commCnt   = comm_cnt_q;
  assign stepFault = step_fault_q;

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// Directed bench for motoro3_gate_driver: inputs driven and outputs sampled on the
// rising edge, half a cycle away from the falling edge the DUT updates on.
module tb_motoro3_gate_driver;

  logic        clk;
  logic        rst;
  logic        pwmActive1;
  logic        pwm;
  logic [3:0]  sgStep;
  logic [7:0]  m3r_deadTime;
  logic [5:0]  gate;
  logic [2:0]  sector;
  logic        deadBusy;
  logic [15:0] commCnt;
  logic        stepFault;

  int total;
  int bad;
  int exp_comm;

  motoro3_gate_driver #(.DT_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwmActive1   (pwmActive1),
    .pwm          (pwm),
    .sgStep       (sgStep),
    .m3r_deadTime (m3r_deadTime),
    .gate         (gate),
    .sector       (sector),
    .deadBusy     (deadBusy),
    .commCnt      (commCnt),
    .stepFault    (stepFault)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Hand-written bridge table, bit order {CL,CH,BL,BH,AL,AH}.
  function automatic logic [5:0] exp_gate(input logic [2:0] s, input logic p);
    case (s)
      3'd0: return {5'b00100, p};
      3'd1: return {5'b10000, p};
      3'd2: return {3'b100, p, 2'b00};
      3'd3: return {3'b000, p, 2'b10};
      3'd4: return {1'b0, p, 4'b0010};
      3'd5: return {1'b0, p, 4'b1000};
      default: return 6'b000000;
    endcase
  endfunction

  always @(posedge clk) begin
    total++;
    if (((gate[0] & gate[1]) | (gate[2] & gate[3]) | (gate[4] & gate[5])) !== 1'b0) begin
      bad++;
      $display("FAIL shoot_through t=%0t gate=%b exp=no leg with H and L", $time, gate);
    end
  end

  // Entered just after a rising edge; the step change that started DEAD was already
  // seen to leave the outputs untouched for one cycle.
  task automatic measure_dead(input string name, input int n, input logic [2:0] exp_sec,
                              input int chg_at, input logic [3:0] chg_a, input logic [3:0] chg_b);
    int off;
    bit leak;
    off  = 0;
    leak = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (!deadBusy) break;
      if (gate !== 6'b0) leak = 1'b1;
      off++;
      if (chg_at > 0 && off == chg_at) sgStep = chg_a;
      if (chg_at > 0 && off == 2 * chg_at) sgStep = chg_b;
    end
    exp_comm++;
    total++;
    if (off !== n) begin
      bad++;
      $display("FAIL %s dead_len got=%0d exp=%0d", name, off, n);
    end
    total++;
    if (leak !== 1'b0) begin
      bad++;
      $display("FAIL %s dead_gate got=nonzero exp=0", name);
    end
    total++;
    if (sector !== exp_sec) begin
      bad++;
      $display("FAIL %s sector got=%0d exp=%0d", name, sector, exp_sec);
    end
    total++;
    if (gate !== exp_gate(exp_sec, pwm)) begin
      bad++;
      $display("FAIL %s gate got=%b exp=%b", name, gate, exp_gate(exp_sec, pwm));
    end
    total++;
    if (commCnt !== exp_comm[15:0]) begin
      bad++;
      $display("FAIL %s comm got=%0d exp=%0d", name, commCnt, exp_comm);
    end
  endtask

  task automatic change_step(input string name, input logic [3:0] step, input int n,
                             input logic [2:0] exp_sec);
    sgStep = step;
    @(posedge clk);
    total++;
    if (deadBusy !== 1'b0) begin
      bad++;
      $display("FAIL %s early_dead got=%b exp=0", name, deadBusy);
    end
    measure_dead(name, n, exp_sec, 0, 4'd0, 4'd0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    total++;
    if (gate !== 6'b0) begin bad++; $display("FAIL reset_gate got=%b exp=0", gate); end
    total++;
    if (sector !== 3'd7) begin bad++; $display("FAIL reset_sector got=%0d exp=7", sector); end
    total++;
    if (deadBusy !== 1'b0) begin bad++; $display("FAIL reset_dead got=%b exp=0", deadBusy); end
    total++;
    if (commCnt !== 16'd0) begin bad++; $display("FAIL reset_comm got=%0d exp=0", commCnt); end
    total++;
    if (stepFault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", stepFault); end
    rst = 1'b0;
  endtask

  task automatic test_enable_pwm();
    logic p;
    logic [5:0] eg;
    m3r_deadTime = 8'd5;
    sgStep       = 4'd0;
    pwm          = 1'b0;
    pwmActive1   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      if (c == 1) begin
        total++;
        if (deadBusy !== 1'b0 || gate !== 6'b0) begin
          bad++;
          $display("FAIL en_latency c=%0d got=%b/%b exp=0/0", c, deadBusy, gate);
        end
      end else if (c <= 6) begin
        total++;
        if (deadBusy !== 1'b1 || gate !== 6'b0 || sector !== 3'd7) begin
          bad++;
          $display("FAIL en_dead c=%0d got=%b/%b/%0d exp=1/0/7", c, deadBusy, gate, sector);
        end
      end
    end
    exp_comm = 1;
    total++;
    if (sector !== 3'd0 || deadBusy !== 1'b0) begin
      bad++;
      $display("FAIL en_run got=%0d/%b exp=0/0", sector, deadBusy);
    end
    total++;
    if (commCnt !== 16'd1) begin bad++; $display("FAIL en_comm got=%0d exp=1", commCnt); end
    // 3 high / 5 low; the AH leg must echo it two cycles later
    for (int i = 0; i < 24; i++) begin
      p  = (i >= 2) ? (((i - 2) % 8) < 3) : 1'b0;
      eg = {5'b00100, p};
      total++;
      if (gate !== eg) begin
        bad++;
        $display("FAIL pwm_follow i=%0d got=%b exp=%b", i, gate, eg);
      end
      pwm = ((i % 8) < 3);
      @(posedge clk);
    end
    pwm = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_sequence();
    m3r_deadTime = 8'd3;
    change_step("seq1", 4'd2, 3, 3'd1);
    change_step("seq2", 4'd4, 3, 3'd2);
    change_step("seq3", 4'd6, 3, 3'd3);
    change_step("seq4", 4'd8, 3, 3'd4);
    change_step("seq5", 4'd10, 3, 3'd5);
    change_step("seq0", 4'd0, 3, 3'd0);
    total++;
    if (commCnt !== 16'd7) begin bad++; $display("FAIL seq_comm got=%0d exp=7", commCnt); end
    total++;
    if (stepFault !== 1'b0) begin bad++; $display("FAIL seq_fault got=%b exp=0", stepFault); end
  endtask

  task automatic test_jump();
    change_step("jump", 4'd6, 3, 3'd3);
    total++;
    if (stepFault !== 1'b1) begin bad++; $display("FAIL jump_fault got=%b exp=1", stepFault); end
    change_step("after_jump", 4'd8, 3, 3'd4);
    total++;
    if (stepFault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b exp=1", stepFault); end
  endtask

  task automatic test_dead_time();
    m3r_deadTime = 8'd0;
    change_step("dt_zero", 4'd10, 1, 3'd5);
    m3r_deadTime = 8'd10;
    sgStep = 4'd0;
    @(posedge clk);
    total++;
    if (deadBusy !== 1'b0) begin bad++; $display("FAIL dbl_early got=%b exp=0", deadBusy); end
    measure_dead("dt_double", 10, 3'd2, 3, 4'd2, 4'd4);
  endtask

  task automatic test_abort();
    m3r_deadTime = 8'd4;
    pwmActive1   = 1'b0;
    @(posedge clk);
    total++;
    if (gate !== exp_gate(3'd2, 1'b1)) begin
      bad++;
      $display("FAIL abort_hold got=%b exp=%b", gate, exp_gate(3'd2, 1'b1));
    end
    @(posedge clk);
    total++;
    if (gate !== 6'b0 || sector !== 3'd7 || deadBusy !== 1'b0) begin
      bad++;
      $display("FAIL abort_off got=%b/%0d/%b exp=0/7/0", gate, sector, deadBusy);
    end
    pwmActive1 = 1'b1;
    @(posedge clk);
    total++;
    if (gate !== 6'b0 || deadBusy !== 1'b0) begin
      bad++;
      $display("FAIL reenable_idle got=%b/%b exp=0/0", gate, deadBusy);
    end
    measure_dead("reenable", 4, 3'd2, 0, 4'd0, 4'd0);
    sgStep = 4'd13;
    repeat (2) @(posedge clk);
    total++;
    if (gate !== 6'b0 || sector !== 3'd7) begin
      bad++;
      $display("FAIL bad_step got=%b/%0d exp=0/7", gate, sector);
    end
    sgStep = 4'd4;
    @(posedge clk);
    measure_dead("bad_step_recover", 4, 3'd2, 0, 4'd0, 4'd0);
  endtask

  task automatic test_reset_busy();
    rst = 1'b1;
    @(posedge clk);
    total++;
    if (gate !== 6'b0 || sector !== 3'd7) begin
      bad++;
      $display("FAIL rst_busy got=%b/%0d exp=0/7", gate, sector);
    end
    total++;
    if (commCnt !== 16'd0 || stepFault !== 1'b0 || deadBusy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_regs got=%0d/%b/%b exp=0/0/0", commCnt, stepFault, deadBusy);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    exp_comm     = 0;
    rst          = 1'b1;
    pwmActive1   = 1'b0;
    pwm          = 1'b0;
    sgStep       = 4'd0;
    m3r_deadTime = 8'd0;
    test_reset();
    test_enable_pwm();
    test_sequence();
    test_jump();
    test_dead_time();
    test_abort();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
